// File: rtl/spi1_sram_bridge.sv
// SPI1 bus target that turns each bus cycle into one timed async SRAM access.
// Accesses launch only in a granted slot; all outputs are registered.
module spi1_sram_bridge #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 3,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic [17:0] wb_addr_i,
  input  logic [7:0]  wb_data_i,
  output logic [7:0]  wb_data_o,
  input  logic        wb_we_i,
  input  logic        wb_cycle_i,
  output logic        wb_ack_o,
  input  logic        grant_i,
  output logic        busy_o,
  output logic [17:0] ram_addr_o,
  input  logic [7:0]  ram_data_i,
  output logic [7:0]  ram_data_o,
  output logic        ram_data_oe_o,
  output logic        ram_ce_no,
  output logic        ram_oe_no,
  output logic        ram_we_no
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   =
    4'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam bit         NO_HOLD   = (HOLD_CYCLES == 0);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GRANT,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [17:0] addr_q;
  logic [7:0]  data_q;
  logic        we_q;

  logic capture;
  logic launch;
  logic sample;
  logic finish;
  logic ce_d;
  logic oe_d;
  logic wen_d;
  logic doe_d;
  logic ack_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    launch  = 1'b0;
    sample  = 1'b0;
    finish  = 1'b0;
    ce_d    = ram_ce_no;
    oe_d    = 1'b1;
    wen_d   = 1'b1;
    doe_d   = ram_data_oe_o;
    ack_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wb_cycle_i) begin
          capture = 1'b1;
          state_d = WAIT_GRANT;
        end
      end
      WAIT_GRANT: begin
        if (!wb_cycle_i) begin
          state_d = IDLE;
        end else if (grant_i) begin
          launch  = 1'b1;
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          ce_d    = 1'b0;
          doe_d   = we_q;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
          oe_d    = we_q;
          wen_d   = !we_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          // Last strobe edge: read data is sampled as the strobe releases.
          sample = !we_q;
          if (NO_HOLD) begin
            finish = 1'b1;
          end else begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
          oe_d  = we_q;
          wen_d = !we_q;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (!wb_cycle_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ack only if the master is still waiting; an abandoned access just ends.
    if (finish) begin
      state_d = DONE;
      ce_d    = 1'b1;
      doe_d   = 1'b0;
      ack_d   = wb_cycle_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      addr_q <= 18'd0;
      data_q <= 8'd0;
      we_q   <= 1'b0;
    end else if (capture) begin
      addr_q <= wb_addr_i;
      data_q <= wb_data_i;
      we_q   <= wb_we_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ram_ce_no     <= 1'b1;
      ram_oe_no     <= 1'b1;
      ram_we_no     <= 1'b1;
      ram_data_oe_o <= 1'b0;
      ram_addr_o    <= 18'd0;
      ram_data_o    <= 8'd0;
      wb_ack_o      <= 1'b0;
      wb_data_o     <= 8'd0;
      busy_o        <= 1'b0;
    end else begin
      ram_ce_no     <= ce_d;
      ram_oe_no     <= oe_d;
      ram_we_no     <= wen_d;
      ram_data_oe_o <= doe_d;
      wb_ack_o      <= ack_d;
      busy_o        <= (state_d != IDLE);
      if (launch) begin
        ram_addr_o <= addr_q;
      end
      if (launch && we_q) begin
        ram_data_o <= data_q;
      end
      if (sample) begin
        wb_data_o <= ram_data_i;
      end
    end
  end

endmodule
